// File: rtl/uart_rx_engine.sv
// uart_rx_engine
// ---------------------------------------------------------------------------
// UART receive engine. The serial line is synchronised, the start bit is
// detected and confirmed at mid-bit, data bits are sampled once per bit
// time (LSB first), and then parity and the stop bit are checked. The
// decoded byte is presented with a ready flag and error flags.
//
// Ports
//   clk      in   system clock
//   reset    in   asynchronous reset, active low
//   rx       in   serial input (idles high, asynchronous to clk)
//   k        in   clocks per bit time (frames are received only if k >= 4)
//   eight    in   1 = 8 data bits, 0 = 7 data bits
//   pen      in   parity enable
//   ohel     in   parity sense: 1 = odd, 0 = even
//   rd       in   one-cycle host read strobe; clears rdy/perr/ferr/ovf
//   rx_data  out  received byte (bit 7 is 0 in 7-bit mode)
//   rdy      out  byte available
//   perr     out  parity error on the last frame
//   ferr     out  framing error (stop bit sampled low)
//   ovf      out  frame completed while rdy was still set
// ---------------------------------------------------------------------------
module uart_rx_engine #(
  parameter int DIV_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic [DIV_W-1:0] k,
  input  logic             eight,
  input  logic             pen,
  input  logic             ohel,
  input  logic             rd,
  output logic [7:0]       rx_data,
  output logic             rdy,
  output logic             perr,
  output logic             ferr,
  output logic             ovf
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [DIV_W-1:0] btc_q, btc_d;
  logic [3:0]       bc_q, bc_d;
  logic [9:0]       sr_q, sr_d;
  logic             stop_q, stop_d;
  logic [7:0]       data_q, data_d;
  logic             rdy_q, rdy_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovf_q, ovf_d;

  logic             rxs;
  logic             k_ok;
  logic [DIV_W-1:0] half_bit;
  logic [DIV_W-1:0] last_cnt;
  logic [3:0]       nbits;
  logic [3:0]       bc_inc;
  logic [9:0]       frame_w;
  logic [7:0]       dec_data;

  // Received bits enter at sr[9] and move down, so after N shifts the frame
  // sits in the top N bits; shifting right by 10-N aligns the first bit at 0.
  function automatic logic [9:0] align_frame(input logic [9:0] sr,
                                             input logic [3:0] n);
    align_frame = sr >> (4'd10 - n);
  endfunction

  // Parity error: data xor parity bit must equal the selected sense.
  function automatic logic parity_error(input logic [7:0] data,
                                        input logic [9:0] w,
                                        input logic [3:0] n,
                                        input logic       en,
                                        input logic       odd);
    parity_error = en & ((^data) ^ w[n - 4'd1] ^ odd);
  endfunction

  assign rxs      = sync2_q;
  assign k_ok     = (k >= DIV_W'(4));
  assign half_bit = k >> 1;
  assign last_cnt = k - DIV_W'(1);
  assign nbits    = (eight ? 4'd8 : 4'd7) + {3'b000, pen};
  assign bc_inc   = bc_q + 4'd1;
  assign frame_w  = align_frame(sr_q, nbits);
  assign dec_data = eight ? frame_w[7:0] : {1'b0, frame_w[6:0]};

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      btc_q   <= '0;
      bc_q    <= '0;
      sr_q    <= 10'h3FF;
      stop_q  <= 1'b1;
      data_q  <= 8'h00;
      rdy_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      btc_q   <= btc_d;
      bc_q    <= bc_d;
      sr_q    <= sr_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    btc_d   = btc_q;
    bc_d    = bc_q;
    sr_d    = sr_q;
    stop_d  = stop_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovf_d   = ovf_q;

    // Host read clears the flags; a frame completing in the same cycle
    // overrides this below.
    if (rd) begin
      rdy_d  = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
      ovf_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        btc_d = '0;
        if (k_ok && !rxs) begin
          state_d = START;
        end
      end

      // Confirm the start bit at mid-bit; a high line means a glitch.
      START: begin
        if (btc_q == half_bit) begin
          btc_d = '0;
          if (!rxs) begin
            state_d = DATA;
            bc_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          btc_d = btc_q + DIV_W'(1);
        end
      end

      DATA: begin
        if (btc_q == last_cnt) begin
          btc_d = '0;
          sr_d  = {rxs, sr_q[9:1]};
          bc_d  = bc_inc;
          if (bc_inc == nbits) begin
            state_d = STOP;
          end
        end else begin
          btc_d = btc_q + DIV_W'(1);
        end
      end

      STOP: begin
        if (btc_q == last_cnt) begin
          btc_d   = '0;
          stop_d  = rxs;
          state_d = DONE;
        end else begin
          btc_d = btc_q + DIV_W'(1);
        end
      end

      DONE: begin
        btc_d   = '0;
        data_d  = dec_data;
        perr_d  = parity_error(dec_data, frame_w, nbits, pen, ohel);
        ferr_d  = ~stop_q;
        ovf_d   = rdy_q;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end

      default: begin
        btc_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data = data_q;
  assign rdy     = rdy_q;
  assign perr    = perr_q;
  assign ferr    = ferr_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
module tb_uart_rx_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [18:0] k;
  logic        eight, pen, ohel, rd;
  logic [7:0]  rx_data;
  logic        rdy, perr, ferr, ovf;

  int checks = 0;
  int passed = 0;

  // Reference model of the host-visible registers.
  logic [7:0] m_data;
  logic       m_rdy, m_perr, m_ferr, m_ovf;

  logic [11:0] got_v, exp_v;

  always #5 clk = ~clk;

  uart_rx_engine #(.DIV_W(19)) dut (
    .clk(clk), .reset(reset), .rx(rx), .k(k), .eight(eight), .pen(pen),
    .ohel(ohel), .rd(rd), .rx_data(rx_data), .rdy(rdy), .perr(perr),
    .ferr(ferr), .ovf(ovf)
  );

  task automatic model_clear();
    m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
  endtask

  // Drive one full frame onto rx. bad_par flips the correct parity bit,
  // stop_bit is the level driven during the stop bit, rd_at_done pulses rd
  // in the cycle the engine finishes the frame. The model is updated from
  // the bits actually placed on the line.
  task automatic send_frame(input logic [7:0] d, input logic bad_par,
                            input logic stop_bit, input logic rd_at_done);
    int nd, nb, ones, cnt, target;
    logic p;
    logic bits [$];
    nd = eight ? 8 : 7;
    nb = nd + (pen ? 1 : 0);
    ones = 0;
    for (int i = 0; i < nd; i++) ones += d[i];
    p = ohel ? ((ones % 2) == 0) : ((ones % 2) == 1);
    if (bad_par) p = ~p;
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(p);
    bits.push_back(stop_bit);
    target = rd_at_done ? (4 + int'(k >> 1) + int'(k) * (nb + 1)) : -1;
    cnt = 0;
    @(negedge clk);
    foreach (bits[b]) begin
      rx = bits[b];
      for (int c = 0; c < int'(k); c++) begin
        @(negedge clk);
        cnt++;
        rd = (cnt == target);
      end
    end
    rx = 1'b1;
    rd = 1'b0;
    if (k >= 4) begin
      m_ovf  = m_rdy;
      m_rdy  = 1'b1;
      m_data = eight ? d : {1'b0, d[6:0]};
      m_perr = pen && (((ones + (p ? 1 : 0)) % 2) != (ohel ? 1 : 0));
      m_ferr = !stop_bit;
    end
    repeat (2 * int'(k) + 4) @(negedge clk);
  endtask

  task automatic host_read();
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b0; rx = 1'b1; rd = 1'b0; k = 19'd16;
    eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    m_data = 8'h00; model_clear();
    #1;
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = 12'h000;
    checks++; if (got_v !== exp_v) $display("FAIL reset_state got=%h exp=%h", got_v, exp_v); else passed++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    k = 19'd16; eight = 1'b1; pen = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = {m_data, m_rdy, m_perr, m_ferr, m_ovf};
    checks++; if (got_v !== exp_v) $display("FAIL basic_a5 got=%h exp=%h", got_v, exp_v); else passed++;
    host_read();
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = {8'hA5, 4'b0000};
    checks++; if (got_v !== exp_v) $display("FAIL rd_clear got=%h exp=%h", got_v, exp_v); else passed++;
  endtask

  task automatic test_parity();
    k = 19'd16; eight = 1'b1; pen = 1'b1; ohel = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = {8'h3C, 4'b1100};
    checks++; if (got_v !== exp_v) $display("FAIL parity_bad got=%h exp=%h", got_v, exp_v); else passed++;
    host_read();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = {8'h3C, 4'b1000};
    checks++; if (got_v !== exp_v) $display("FAIL parity_good got=%h exp=%h", got_v, exp_v); else passed++;
    host_read();
  endtask

  task automatic test_seven_bit();
    k = 19'd16; eight = 1'b0; pen = 1'b1; ohel = 1'b1;
    send_frame(8'hD5, 1'b0, 1'b1, 1'b0);
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = {8'h55, 4'b1000};
    checks++; if (got_v !== exp_v) $display("FAIL seven_bit got=%h exp=%h", got_v, exp_v); else passed++;
    host_read();
  endtask

  task automatic test_framing();
    k = 19'd16; eight = 1'b1; pen = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = {8'h81, 4'b1010};
    checks++; if (got_v !== exp_v) $display("FAIL framing got=%h exp=%h", got_v, exp_v); else passed++;
    host_read();
  endtask

  task automatic test_glitch();
    k = 19'd16; eight = 1'b1; pen = 1'b0;
    @(negedge clk); rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (48) @(negedge clk);
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = {m_data, m_rdy, m_perr, m_ferr, m_ovf};
    checks++; if (got_v !== exp_v) $display("FAIL glitch_ignored got=%h exp=%h", got_v, exp_v); else passed++;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = {8'h5A, 4'b1000};
    checks++; if (got_v !== exp_v) $display("FAIL after_glitch got=%h exp=%h", got_v, exp_v); else passed++;
    host_read();
  endtask

  task automatic test_back_to_back();
    k = 19'd16; eight = 1'b1; pen = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = {8'h11, 4'b1000};
    checks++; if (got_v !== exp_v) $display("FAIL first_of_two got=%h exp=%h", got_v, exp_v); else passed++;
    send_frame(8'h22, 1'b0, 1'b1, 1'b1);
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = {8'h22, 4'b1001};
    checks++; if (got_v !== exp_v) $display("FAIL overrun_rd_same_cycle got=%h exp=%h", got_v, exp_v); else passed++;
    got_v = {m_data, m_rdy, m_perr, m_ferr, m_ovf};
    checks++; if (got_v !== {rx_data, rdy, perr, ferr, ovf}) $display("FAIL overrun_model got=%h exp=%h", {rx_data, rdy, perr, ferr, ovf}, got_v); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    k = 19'd16; eight = 1'b1; pen = 1'b0;
    d = 8'hF0;
    @(negedge clk); rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    m_data = 8'h00; model_clear();
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = 12'h000;
    checks++; if (got_v !== exp_v) $display("FAIL reset_mid_frame got=%h exp=%h", got_v, exp_v); else passed++;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = {8'h0F, 4'b1000};
    checks++; if (got_v !== exp_v) $display("FAIL after_reset_frame got=%h exp=%h", got_v, exp_v); else passed++;
    host_read();
  endtask

  task automatic test_k_small();
    k = 19'd3; eight = 1'b1; pen = 1'b0;
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = {m_data, 4'b0000};
    checks++; if (got_v !== exp_v) $display("FAIL k_below_4 got=%h exp=%h", got_v, exp_v); else passed++;
    k = 19'd16;
    repeat (4) @(negedge clk);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = {8'hC3, 4'b1000};
    checks++; if (got_v !== exp_v) $display("FAIL k_restore got=%h exp=%h", got_v, exp_v); else passed++;
    host_read();
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      k     = 19'($urandom_range(12, 40));
      eight = 1'($urandom_range(0, 1));
      pen   = 1'($urandom_range(0, 1));
      ohel  = 1'($urandom_range(0, 1));
      send_frame(8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), 1'b0);
      got_v = {rx_data, rdy, perr, ferr, ovf}; exp_v = {m_data, m_rdy, m_perr, m_ferr, m_ovf};
      checks++; if (got_v !== exp_v) $display("FAIL random_frame_%0d got=%h exp=%h", n, got_v, exp_v); else passed++;
      if ($urandom_range(0, 1) == 1) host_read();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_seven_bit();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_k_small();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
